cv_alu_decode_stage: RTL

Registered decode stage for the CV32E40P custom ALU, custom-immediate and immediate-branch instruction subset (opcodes 0x2B, 0x5B, 0x0B). It accepts raw 32-bit instruction words on a valid/ready handshake and emits the internal ALU operation code plus operand fields one cycle later. A two-entry skid buffer sustains full throughput under backpressure. It sits between the instruction source (fetch model or stimulus driver) and the ALU/reference-model consumer, and keeps saturating statistics counters.

---
 rtl/cv_alu_decode_stage.sv | 327 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/cv_alu_decode_stage.sv
// cv_alu_decode_stage
// Registered decode stage for the CV32E40P custom ALU (0x2B), custom-immediate
// (0x5B) and immediate-branch (0x0B) instruction subset. It takes raw instruction
// words on a valid/ready handshake and presents the internal ALU operation code
// and operand fields one cycle later. A main register and a skid register keep
// the stage at full throughput under backpressure. Saturating counters track
// the entries the consumer accepts.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   in_valid/in_ready         instruction handshake (in_ready = skid not full)
//   in_instr[31:0]            raw instruction word
//   out_valid/out_ready       decoded-entry handshake
//   out_alu_op[6:0]           internal ALU operation code
//   out_rd/rs1/rs2/is3/is2    raw register/immediate field slices
//   out_cmp_imm, out_br_off   sign-extended compare immediate, B-type offset
//   out_use_imm/use_rs2/use_rd/ext_half/branch/illegal   decode flags
//   cnt_decoded, cnt_illegal  saturating counts of consumed entries
module cv_alu_decode_stage #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [6:0]       out_alu_op,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_is3,
    output logic [4:0]       out_is2,
    output logic [31:0]      out_cmp_imm,
    output logic [31:0]      out_br_off,
    output logic             out_use_imm,
    output logic             out_use_rs2,
    output logic             out_use_rd,
    output logic             out_ext_half,
    output logic             out_branch,
    output logic             out_illegal,
    output logic [CNT_W-1:0] cnt_decoded,
    output logic [CNT_W-1:0] cnt_illegal
);

    localparam int unsigned OP_W  = 7;
    localparam int unsigned HI_W  = 17;   // instr[31:15]
    localparam int unsigned REG_W = 5;

    localparam logic [6:0] OPC_ALU = 7'h2B;
    localparam logic [6:0] OPC_IMM = 7'h5B;
    localparam logic [6:0] OPC_BR  = 7'h0B;

    localparam logic [OP_W-1:0] ALU_ADD   = 7'b0011000;
    localparam logic [OP_W-1:0] ALU_SUB   = 7'b0011001;
    localparam logic [OP_W-1:0] ALU_ADDU  = 7'b0011010;
    localparam logic [OP_W-1:0] ALU_SUBU  = 7'b0011011;
    localparam logic [OP_W-1:0] ALU_ADDR  = 7'b0011100;
    localparam logic [OP_W-1:0] ALU_SUBR  = 7'b0011101;
    localparam logic [OP_W-1:0] ALU_ADDUR = 7'b0011110;
    localparam logic [OP_W-1:0] ALU_SUBUR = 7'b0011111;
    localparam logic [OP_W-1:0] ALU_ROR   = 7'b0100110;
    localparam logic [OP_W-1:0] ALU_BEXT  = 7'b0101000;
    localparam logic [OP_W-1:0] ALU_BEXTU = 7'b0101001;
    localparam logic [OP_W-1:0] ALU_BINS  = 7'b0101010;
    localparam logic [OP_W-1:0] ALU_BCLR  = 7'b0101011;
    localparam logic [OP_W-1:0] ALU_BSET  = 7'b0101100;
    localparam logic [OP_W-1:0] ALU_BREV  = 7'b1001001;
    localparam logic [OP_W-1:0] ALU_FF1   = 7'b0110110;
    localparam logic [OP_W-1:0] ALU_FL1   = 7'b0110111;
    localparam logic [OP_W-1:0] ALU_CNT   = 7'b0110100;
    localparam logic [OP_W-1:0] ALU_CLB   = 7'b0110101;
    localparam logic [OP_W-1:0] ALU_EXTS  = 7'b0111110;
    localparam logic [OP_W-1:0] ALU_EXT   = 7'b0111111;
    localparam logic [OP_W-1:0] ALU_EQ    = 7'b0001100;
    localparam logic [OP_W-1:0] ALU_NE    = 7'b0001101;
    localparam logic [OP_W-1:0] ALU_SLETS = 7'b0000110;
    localparam logic [OP_W-1:0] ALU_SLETU = 7'b0000111;
    localparam logic [OP_W-1:0] ALU_ABS   = 7'b0010100;
    localparam logic [OP_W-1:0] ALU_CLIP  = 7'b0010110;
    localparam logic [OP_W-1:0] ALU_CLIPU = 7'b0010111;
    localparam logic [OP_W-1:0] ALU_MIN   = 7'b0010000;
    localparam logic [OP_W-1:0] ALU_MINU  = 7'b0010001;
    localparam logic [OP_W-1:0] ALU_MAX   = 7'b0010010;
    localparam logic [OP_W-1:0] ALU_MAXU  = 7'b0010011;

    // Only the instruction bits that feed output fields are kept in the buffers.
    typedef struct packed {
        logic [HI_W-1:0]  hi;       // instr[31:15]
        logic [REG_W-1:0] rd;       // instr[11:7]
        logic [OP_W-1:0]  alu_op;
        logic             use_imm;
        logic             use_rs2;
        logic             use_rd;
        logic             ext_half;
        logic             branch;
        logic             illegal;
    } entry_t;

    entry_t dec_c;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   main_vld_q, main_vld_d;
    logic   skid_vld_q, skid_vld_d;
    logic [CNT_W-1:0] cnt_dec_q, cnt_dec_d;
    logic [CNT_W-1:0] cnt_ill_q, cnt_ill_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [1:0] funct2;
    logic       accept_c;
    logic       consume_c;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];
    assign funct2 = in_instr[31:30];

    // Instruction decode; anything unmatched falls through as illegal.
    always_comb begin
        dec_c          = '0;
        dec_c.hi       = in_instr[31:15];
        dec_c.rd       = in_instr[11:7];
        dec_c.alu_op   = ALU_ADD;
        dec_c.illegal  = 1'b1;
        case (opcode)
            OPC_ALU: begin
                if (funct3 == 3'b011) begin
                    dec_c.illegal = 1'b0;
                    dec_c.use_rs2 = 1'b1;
                    case (funct7)
                        7'h18: dec_c.alu_op = ALU_BEXT;
                        7'h19: dec_c.alu_op = ALU_BEXTU;
                        7'h1A: begin dec_c.alu_op = ALU_BINS; dec_c.use_rd = 1'b1; end
                        7'h1C: dec_c.alu_op = ALU_BCLR;
                        7'h1D: dec_c.alu_op = ALU_BSET;
                        7'h20: dec_c.alu_op = ALU_ROR;
                        7'h21: begin dec_c.alu_op = ALU_FF1; dec_c.use_rs2 = 1'b0; end
                        7'h22: begin dec_c.alu_op = ALU_FL1; dec_c.use_rs2 = 1'b0; end
                        7'h23: begin dec_c.alu_op = ALU_CLB; dec_c.use_rs2 = 1'b0; end
                        7'h24: begin dec_c.alu_op = ALU_CNT; dec_c.use_rs2 = 1'b0; end
                        7'h28: begin dec_c.alu_op = ALU_ABS; dec_c.use_rs2 = 1'b0; end
                        7'h29: dec_c.alu_op = ALU_SLETS;
                        7'h2A: dec_c.alu_op = ALU_SLETU;
                        7'h2B: dec_c.alu_op = ALU_MIN;
                        7'h2C: dec_c.alu_op = ALU_MINU;
                        7'h2D: dec_c.alu_op = ALU_MAX;
                        7'h2E: dec_c.alu_op = ALU_MAXU;
                        7'h30: begin
                            dec_c.alu_op   = ALU_EXTS;
                            dec_c.use_rs2  = 1'b0;
                            dec_c.ext_half = 1'b1;
                        end
                        7'h31: begin
                            dec_c.alu_op   = ALU_EXT;
                            dec_c.use_rs2  = 1'b0;
                            dec_c.ext_half = 1'b1;
                        end
                        7'h32: begin dec_c.alu_op = ALU_EXTS; dec_c.use_rs2 = 1'b0; end
                        7'h33: begin dec_c.alu_op = ALU_EXT;  dec_c.use_rs2 = 1'b0; end
                        7'h38: begin
                            dec_c.alu_op  = ALU_CLIP;
                            dec_c.use_rs2 = 1'b0;
                            dec_c.use_imm = 1'b1;
                        end
                        7'h39: begin
                            dec_c.alu_op  = ALU_CLIPU;
                            dec_c.use_rs2 = 1'b0;
                            dec_c.use_imm = 1'b1;
                        end
                        7'h3A: dec_c.alu_op = ALU_CLIP;
                        7'h3B: dec_c.alu_op = ALU_CLIPU;
                        7'h40: dec_c.alu_op = ALU_ADD;
                        7'h41: dec_c.alu_op = ALU_ADDU;
                        7'h42: dec_c.alu_op = ALU_ADDR;
                        7'h43: dec_c.alu_op = ALU_ADDUR;
                        7'h44: dec_c.alu_op = ALU_SUB;
                        7'h45: dec_c.alu_op = ALU_SUBU;
                        7'h46: dec_c.alu_op = ALU_SUBR;
                        7'h47: dec_c.alu_op = ALU_SUBUR;
                        default: dec_c.illegal = 1'b1;
                    endcase
                end
            end
            OPC_IMM: begin
                dec_c.illegal = 1'b0;
                dec_c.use_imm = 1'b1;
                case (funct3)
                    3'b000: begin
                        case (funct2)
                            2'b00:   dec_c.alu_op = ALU_BEXT;
                            2'b01:   dec_c.alu_op = ALU_BEXTU;
                            2'b10:   begin dec_c.alu_op = ALU_BINS; dec_c.use_rd = 1'b1; end
                            default: dec_c.illegal = 1'b1;
                        endcase
                    end
                    3'b001: begin
                        case (funct2)
                            2'b00:   dec_c.alu_op = ALU_BCLR;
                            2'b01:   dec_c.alu_op = ALU_BSET;
                            2'b11:   dec_c.alu_op = ALU_BREV;
                            default: dec_c.illegal = 1'b1;
                        endcase
                    end
                    3'b010: begin
                        dec_c.use_rs2 = 1'b1;
                        case (funct2)
                            2'b00: dec_c.alu_op = ALU_ADD;
                            2'b01: dec_c.alu_op = ALU_ADDU;
                            2'b10: dec_c.alu_op = ALU_ADDR;
                            2'b11: dec_c.alu_op = ALU_ADDUR;
                        endcase
                    end
                    3'b011: begin
                        dec_c.use_rs2 = 1'b1;
                        case (funct2)
                            2'b00: dec_c.alu_op = ALU_SUB;
                            2'b01: dec_c.alu_op = ALU_SUBU;
                            2'b10: dec_c.alu_op = ALU_SUBR;
                            2'b11: dec_c.alu_op = ALU_SUBUR;
                        endcase
                    end
                    default: dec_c.illegal = 1'b1;
                endcase
            end
            OPC_BR: begin
                if (funct3 == 3'b110 || funct3 == 3'b111) begin
                    dec_c.illegal = 1'b0;
                    dec_c.branch  = 1'b1;
                    dec_c.use_imm = 1'b1;
                    dec_c.alu_op  = funct3[0] ? ALU_NE : ALU_EQ;
                end
            end
            default: ;
        endcase
        // Illegal entries are forwarded as a flag-free ADD.
        if (dec_c.illegal) begin
            dec_c.alu_op   = ALU_ADD;
            dec_c.use_imm  = 1'b0;
            dec_c.use_rs2  = 1'b0;
            dec_c.use_rd   = 1'b0;
            dec_c.ext_half = 1'b0;
            dec_c.branch   = 1'b0;
        end
    end

    assign accept_c  = in_valid && !skid_vld_q;
    assign consume_c = main_vld_q && out_ready;

    // Main/skid buffer next state and saturating counters.
    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        cnt_dec_d  = cnt_dec_q;
        cnt_ill_d  = cnt_ill_q;
        if (consume_c) begin
            // A full skid blocks accept, so refill from skid takes priority.
            if (skid_vld_q) begin
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end else if (accept_c) begin
                main_d = dec_c;
            end else begin
                main_vld_d = 1'b0;
            end
            if (cnt_dec_q != {CNT_W{1'b1}}) begin
                cnt_dec_d = cnt_dec_q + CNT_W'(1);
            end
            if (main_q.illegal && (cnt_ill_q != {CNT_W{1'b1}})) begin
                cnt_ill_d = cnt_ill_q + CNT_W'(1);
            end
        end else if (accept_c) begin
            if (main_vld_q) begin
                skid_d     = dec_c;
                skid_vld_d = 1'b1;
            end else begin
                main_d     = dec_c;
                main_vld_d = 1'b1;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q     <= '0;
            main_vld_q <= 1'b0;
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
            cnt_dec_q  <= '0;
            cnt_ill_q  <= '0;
        end else begin
            main_q     <= main_d;
            main_vld_q <= main_vld_d;
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
            cnt_dec_q  <= cnt_dec_d;
            cnt_ill_q  <= cnt_ill_d;
        end
    end

    // Outputs are direct slices of the main register (hi = instr[31:15]).
    assign in_ready     = !skid_vld_q;
    assign out_valid    = main_vld_q;
    assign out_alu_op   = main_q.alu_op;
    assign out_rd       = main_q.rd;
    assign out_rs1      = main_q.hi[4:0];
    assign out_rs2      = main_q.hi[9:5];
    assign out_is2      = main_q.hi[9:5];
    assign out_is3      = main_q.hi[14:10];
    assign out_cmp_imm  = {{27{main_q.hi[9]}}, main_q.hi[9:5]};
    assign out_br_off   = {{19{main_q.hi[16]}}, main_q.hi[16], main_q.rd[0],
                           main_q.hi[15:10], main_q.rd[4:1], 1'b0};
    assign out_use_imm  = main_q.use_imm;
    assign out_use_rs2  = main_q.use_rs2;
    assign out_use_rd   = main_q.use_rd;
    assign out_ext_half = main_q.ext_half;
    assign out_branch   = main_q.branch;
    assign out_illegal  = main_q.illegal;
    assign cnt_decoded  = cnt_dec_q;
    assign cnt_illegal  = cnt_ill_q;

endmodule
